// File: rtl/icache.sv
// Direct-mapped one-word-line I-cache: hit answers 1 cycle after accept, miss holds a memctrl read until ok; rdy low freezes everything.
// Defining ICACHE_STATS_EN builds the hit/miss counters; otherwise both counter ports read 0.
module icache #(
    parameter int INDEX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        enable_from_if,
    input  logic [31:0] addr_from_if,
    output logic        ok_to_if,
    output logic [31:0] ins_to_if,
    input  logic        mispredict,
    output logic        enable_to_memctrl,
    output logic [31:0] addr_to_memctrl,
    input  logic        ok_from_memctrl,
    input  logic [31:0] ins_from_memctrl,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 16 - INDEX_WIDTH;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [31:0]            data_q [LINES];
    logic [INDEX_WIDTH-1:0] idx_q, idx_d, req_idx;
    logic [TAG_W-1:0]       ltag_q, ltag_d, req_tag;
    logic                   cancel_q, cancel_d;
    logic                   ok_q, ok_d;
    logic [31:0]            ins_q, ins_d;
    logic                   memen_q, memen_d;
    logic [31:0]            memaddr_q, memaddr_d;
    logic                   hit, accept, fill, hit_acc, miss_acc;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = ^addr_from_if[1:0];

    assign req_idx = addr_from_if[INDEX_WIDTH+1:2];
    assign req_tag = addr_from_if[17:INDEX_WIDTH+2];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // The held request is not re-accepted while its own ok pulse is out.
    assign accept  = enable_from_if && !mispredict && !ok_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ltag_d    = ltag_q;
        cancel_d  = cancel_q;
        ok_d      = 1'b0;
        ins_d     = ins_q;
        memen_d   = memen_q;
        memaddr_d = memaddr_q;
        fill      = 1'b0;
        hit_acc   = 1'b0;
        miss_acc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        ok_d    = 1'b1;
                        ins_d   = data_q[req_idx];
                        hit_acc = 1'b1;
                    end else begin
                        memen_d   = 1'b1;
                        memaddr_d = {addr_from_if[31:2], 2'b00};
                        idx_d     = req_idx;
                        ltag_d    = req_tag;
                        cancel_d  = 1'b0;
                        miss_acc  = 1'b1;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                // A flushed refill still lands in the array; only the answer is dropped.
                if (ok_from_memctrl) begin
                    fill    = 1'b1;
                    memen_d = 1'b0;
                    ins_d   = ins_from_memctrl;
                    ok_d    = !(cancel_q || mispredict);
                    state_d = IDLE;
                end else if (mispredict) begin
                    cancel_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            idx_q     <= '0;
            ltag_q    <= '0;
            cancel_q  <= 1'b0;
            ok_q      <= 1'b0;
            ins_q     <= '0;
            memen_q   <= 1'b0;
            memaddr_q <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ltag_q    <= ltag_d;
            cancel_q  <= cancel_d;
            ok_q      <= ok_d;
            ins_q     <= ins_d;
            memen_q   <= memen_d;
            memaddr_q <= memaddr_d;
            if (fill) valid_q[idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_q[idx_q]  <= ltag_q;
            data_q[idx_q] <= ins_from_memctrl;
        end
    end

    assign ok_to_if          = ok_q;
    assign ins_to_if         = ins_q;
    assign enable_to_memctrl = memen_q;
    assign addr_to_memctrl   = memaddr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy) begin
            if (hit_acc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_acc) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;

    assign unused_stats = hit_acc ^ miss_acc;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule
